// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding and register-number constants for the hazard controller
package pipe_ctrl_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] XZR = 5'd31;

    // Countdown is wide enough for the largest branch-flush length (7)
    localparam int CD_W = 3;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_BR_FLUSH = 2'd2,
        ST_MEM_WAIT = 2'd3
    } hz_state_t;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard comparator
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic             idex_memRead,
    input  logic [REG_W-1:0] idex_Rd,
    output logic             hit
);

    // A load into the zero register never produces a real dependency
    always_comb begin
        hit = idex_memRead && (idex_Rd != XZR) &&
              ((id_uses_rn && (id_rn == idex_Rd)) ||
               (id_uses_rm && (id_rm == idex_Rd)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush/freeze controller; HAZ_PERF_CNT_EN adds perf counters
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int BR_FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [REG_W-1:0]     id_rn,
    input  logic [REG_W-1:0]     id_rm,
    input  logic                 id_uses_rn,
    input  logic                 id_uses_rm,
    input  logic                 idex_memRead,
    input  logic [REG_W-1:0]     idex_Rd,
    input  logic                 ex_branch_taken,
    input  logic                 dmem_req,
    input  logic                 dmem_ack,
    output logic                 pc_write,
    output logic                 ifid_write,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 exmem_flush,
    output logic                 idex_hold,
    output logic                 exmem_hold,
`ifdef HAZ_PERF_CNT_EN
    output logic [CNT_WIDTH-1:0] lu_stall_cnt,
    output logic [CNT_WIDTH-1:0] br_flush_cnt,
    output logic [CNT_WIDTH-1:0] mem_wait_cnt,
`endif
    output logic [1:0]           state_o
);

    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(BR_FLUSH_CYCLES);

    hz_state_t       state_q, state_d;
    hz_state_t       saved_q, saved_d;
    logic [CD_W-1:0] cd_q, cd_d;
    logic            lu_hit;
    logic            freeze_in;
    logic            lu_evt, br_evt, frz_evt;

    load_use_detect u_lud (
        .id_rn        (id_rn),
        .id_rm        (id_rm),
        .id_uses_rn   (id_uses_rn),
        .id_uses_rm   (id_uses_rm),
        .idex_memRead (idex_memRead),
        .idex_Rd      (idex_Rd),
        .hit          (lu_hit)
    );

    assign freeze_in = dmem_req && !dmem_ack;
    assign state_o   = state_q;

    // State, saved pre-freeze state and branch countdown registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            saved_q <= ST_RUN;
            cd_q    <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cd_q    <= cd_d;
        end
    end

    // Next state and pipeline controls: freeze > branch > load-use > normal
    always_comb begin
        state_d     = state_q;
        saved_d     = saved_q;
        cd_d        = cd_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        idex_hold   = 1'b0;
        exmem_hold  = 1'b0;
        lu_evt      = 1'b0;
        br_evt      = 1'b0;
        frz_evt     = 1'b0;

        if (state_q == ST_MEM_WAIT) begin
            if (!dmem_ack) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_hold  = 1'b1;
                exmem_hold = 1'b1;
                frz_evt    = 1'b1;
            end else begin
                // Ack cycle: release the pipeline and resume where we left off
                state_d = saved_q;
            end
        end else if (freeze_in) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_hold  = 1'b1;
            exmem_hold = 1'b1;
            frz_evt    = 1'b1;
            state_d    = ST_MEM_WAIT;
            saved_d    = state_q;
        end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            br_evt      = 1'b1;
            state_d     = ST_BR_FLUSH;
            cd_d        = CD_LOAD;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (lu_hit) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                        lu_evt     = 1'b1;
                        state_d    = ST_LU_STALL;
                    end
                end
                ST_LU_STALL: begin
                    state_d = ST_RUN;
                end
                ST_BR_FLUSH: begin
                    if (cd_q <= 3'd1) begin
                        cd_d    = '0;
                        state_d = ST_RUN;
                    end else begin
                        cd_d = cd_q - 3'd1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end

        // Reset drives a bubble into every stage and stops fetch
        if (!reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            idex_hold   = 1'b0;
            exmem_hold  = 1'b0;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    // Saturating event counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lu_stall_cnt <= '0;
            br_flush_cnt <= '0;
            mem_wait_cnt <= '0;
        end else begin
            if (lu_evt && (lu_stall_cnt != '1)) lu_stall_cnt <= lu_stall_cnt + CNT_ONE;
            if (br_evt && (br_flush_cnt != '1)) br_flush_cnt <= br_flush_cnt + CNT_ONE;
            if (frz_evt && (mem_wait_cnt != '1)) mem_wait_cnt <= mem_wait_cnt + CNT_ONE;
        end
    end
`else
    logic unused_evt;
    assign unused_evt = lu_evt ^ br_evt ^ frz_evt;
`endif

endmodule
